// File: rtl/doorlock_pkg.sv
// doorlock_pkg: shared types and constants for the door-lock code checker.
// The NEWPW state exists only when DOORLOCK_PWCHANGE_EN is defined.
package doorlock_pkg;

  localparam int CODE_W    = 4;
  localparam int ENTRY_LEN = 4;

  // Password loaded at reset unless the top-level parameter overrides it.
  localparam logic [CODE_W-1:0] DEFAULT_CODE_INIT = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
`ifdef DOORLOCK_PWCHANGE_EN
    ,
    ST_NEWPW   = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/doorlock_dwell_timer.sv
// doorlock_dwell_timer: load/count-down timer shared by the OPEN and LOCKOUT
// dwell periods. Loading N gives exactly N cycles with the loaded value
// counting N..1; o_done is high in the last of those cycles.
module doorlock_dwell_timer #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/doorlock_code_checker.sv
// doorlock_code_checker: counts bits entered into the upstream 4-bit shift
// register, compares the parallel code against the stored password, and
// drives unlock, failure counting, alarm lockout and a shift-register clear.
// All outputs are registered. Optional password change is enabled by
// defining DOORLOCK_PWCHANGE_EN; without it the password is DEFAULT_CODE.
// o_dbg_state exposes the FSM state for checkers.
module doorlock_code_checker
  import doorlock_pkg::*;
#(
  parameter logic [CODE_W-1:0] DEFAULT_CODE = DEFAULT_CODE_INIT,
  parameter int OPEN_CYCLES = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int MAX_FAIL    = 3
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             bit_stb,
  input  logic [CODE_W-1:0]                code_in,
  input  logic                             cancel,
  input  logic                             pw_set,
  output logic                             unlock,
  output logic                             alarm,
  output logic                             fail_pulse,
  output logic                             sr_clr,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt,
  output logic [2:0]                       entry_cnt,
  output logic [2:0]                       o_dbg_state
);

  localparam int FW        = $clog2(MAX_FAIL + 1);
  localparam int MAX_DWELL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW        = $clog2(MAX_DWELL + 1);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_entry_cnt, w_entry_nxt;
  logic [FW-1:0]     r_fail_cnt, w_fail_nxt, w_fail_inc;
  logic              r_unlock, r_alarm, r_fail_pulse, r_sr_clr;
  logic              w_fail_pulse_nxt, w_sr_clr_nxt;
  logic              w_tmr_load, w_tmr_done;
  logic [TW-1:0]     w_tmr_val;
  logic [CODE_W-1:0] w_code_cur;

`ifdef DOORLOCK_PWCHANGE_EN
  logic [CODE_W-1:0] r_code, w_code_nxt;

  // Stored password; written only when a NEWPW entry completes.
  always_ff @(posedge CLK) begin
    if (RST) r_code <= DEFAULT_CODE;
    else     r_code <= w_code_nxt;
  end

  assign w_code_cur = r_code;
`else
  logic w_unused_pw_set;
  assign w_unused_pw_set = pw_set;
  assign w_code_cur      = DEFAULT_CODE;
`endif

  doorlock_dwell_timer #(.W(TW)) u_dwell_timer (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // Saturating increment so the failure count can never wrap.
  assign w_fail_inc = (r_fail_cnt == FW'(MAX_FAIL)) ? r_fail_cnt : r_fail_cnt + 1'b1;

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    w_state_nxt      = r_state;
    w_entry_nxt      = r_entry_cnt;
    w_fail_nxt       = r_fail_cnt;
    w_fail_pulse_nxt = 1'b0;
    w_sr_clr_nxt     = 1'b0;
    w_tmr_load       = 1'b0;
    w_tmr_val        = '0;
`ifdef DOORLOCK_PWCHANGE_EN
    w_code_nxt       = r_code;
`endif
    case (r_state)
      ST_IDLE, ST_ENTRY: begin
        // cancel beats a simultaneous strobe; that strobe is not counted.
        if (cancel) begin
          w_state_nxt  = ST_IDLE;
          w_entry_nxt  = 3'd0;
          w_sr_clr_nxt = 1'b1;
        end else if (bit_stb) begin
          w_entry_nxt = r_entry_cnt + 3'd1;
          if (r_entry_cnt == 3'(ENTRY_LEN - 1)) w_state_nxt = ST_CHECK;
          else                                  w_state_nxt = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        // The shift register captured the last bit at the previous edge,
        // so code_in is complete here. Strobes in this cycle are dropped.
        w_entry_nxt  = 3'd0;
        w_sr_clr_nxt = 1'b1;
        if (code_in == w_code_cur) begin
          w_state_nxt = ST_OPEN;
          w_fail_nxt  = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(OPEN_CYCLES);
        end else begin
          w_fail_pulse_nxt = 1'b1;
          w_fail_nxt       = w_fail_inc;
          if (w_fail_inc == FW'(MAX_FAIL)) begin
            w_state_nxt = ST_LOCKOUT;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(LOCK_CYCLES);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (cancel) begin
          w_state_nxt = ST_IDLE;
`ifdef DOORLOCK_PWCHANGE_EN
        end else if (pw_set) begin
          w_state_nxt  = ST_NEWPW;
          w_entry_nxt  = 3'd0;
          w_sr_clr_nxt = 1'b1;
`endif
        end else if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_IDLE;
          w_fail_nxt  = '0;
        end
      end
`ifdef DOORLOCK_PWCHANGE_EN
      ST_NEWPW: begin
        // Once four bits are in, the following cycle commits code_in.
        if (cancel) begin
          w_state_nxt  = ST_IDLE;
          w_entry_nxt  = 3'd0;
          w_sr_clr_nxt = 1'b1;
        end else if (r_entry_cnt == 3'(ENTRY_LEN)) begin
          w_code_nxt   = code_in;
          w_state_nxt  = ST_IDLE;
          w_entry_nxt  = 3'd0;
          w_sr_clr_nxt = 1'b1;
        end else if (bit_stb) begin
          w_entry_nxt = r_entry_cnt + 3'd1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_entry_nxt = 3'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_entry_cnt  <= 3'd0;
      r_fail_cnt   <= '0;
      r_unlock     <= 1'b0;
      r_alarm      <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_sr_clr     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_entry_cnt  <= w_entry_nxt;
      r_fail_cnt   <= w_fail_nxt;
      r_unlock     <= (w_state_nxt == ST_OPEN);
      r_alarm      <= (w_state_nxt == ST_LOCKOUT);
      r_fail_pulse <= w_fail_pulse_nxt;
      r_sr_clr     <= w_sr_clr_nxt;
    end
  end

  assign unlock      = r_unlock;
  assign alarm       = r_alarm;
  assign fail_pulse  = r_fail_pulse;
  assign sr_clr      = r_sr_clr;
  assign fail_cnt    = r_fail_cnt;
  assign entry_cnt   = r_entry_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_doorlock_code_checker.sv
// tb_doorlock_code_checker: directed self-checking bench for the door-lock
// code checker with default parameters (code 1010, open 8, lockout 16, 3 fails).
// The shift register upstream is modelled inside the strobe driver.
module tb_doorlock_code_checker;
  import doorlock_pkg::*;

  logic       CLK, RST, bit_stb, cancel, pw_set;
  logic [3:0] code_in;
  logic       unlock, alarm, fail_pulse, sr_clr;
  logic [1:0] fail_cnt;
  logic [2:0] entry_cnt, o_dbg_state;
  logic [3:0] sr;
  int         checks, failures;

  doorlock_code_checker dut (
    .CLK(CLK), .RST(RST), .bit_stb(bit_stb), .code_in(code_in),
    .cancel(cancel), .pw_set(pw_set), .unlock(unlock), .alarm(alarm),
    .fail_pulse(fail_pulse), .sr_clr(sr_clr), .fail_cnt(fail_cnt),
    .entry_cnt(entry_cnt), .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input logic b);
    bit_stb = 1'b1;
    tick();
    bit_stb = 1'b0;
    sr      = {b, sr[3:1]};
    code_in = sr;
  endtask

  task automatic enter_code(input logic [3:0] c);
    sr      = 4'b0;
    code_in = 4'b0;
    for (int i = 0; i < 4; i++) strobe(c[i]);
  endtask

  task automatic close_door();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    if (unlock !== 1'b0) begin failures++; $display("FAIL close_door unlock got=%b exp=0", unlock); end
    checks++;
  endtask

  // Tests
  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    if ({unlock, alarm, fail_pulse, sr_clr} !== 4'b0000) begin failures++; $display("FAIL reset_outs got=%b exp=0000", {unlock, alarm, fail_pulse, sr_clr}); end
    checks++;
    if (fail_cnt !== 2'd0) begin failures++; $display("FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
    checks++;
    if (entry_cnt !== 3'd0) begin failures++; $display("FAIL reset_entry_cnt got=%0d exp=0", entry_cnt); end
    checks++;
    if (o_dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", o_dbg_state, ST_IDLE); end
    checks++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_correct_code();
    enter_code(4'b1010);
    if (entry_cnt !== 3'd4 || o_dbg_state !== ST_CHECK || unlock !== 1'b0) begin
      failures++; $display("FAIL ok_check_cycle entry=%0d state=%0d unlock=%b exp 4/%0d/0", entry_cnt, o_dbg_state, unlock, ST_CHECK);
    end
    checks++;
    tick();
    if (unlock !== 1'b1 || sr_clr !== 1'b1 || fail_cnt !== 2'd0 || entry_cnt !== 3'd0) begin
      failures++; $display("FAIL ok_open1 unlock=%b sr_clr=%b fail=%0d entry=%0d exp 1/1/0/0", unlock, sr_clr, fail_cnt, entry_cnt);
    end
    checks++;
    bit_stb = 1'b1;  // strobes are ignored while open
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (unlock !== 1'b1 || sr_clr !== 1'b0 || entry_cnt !== 3'd0) begin
        failures++; $display("FAIL ok_open%0d unlock=%b sr_clr=%b entry=%0d exp 1/0/0", i, unlock, sr_clr, entry_cnt);
      end
      checks++;
    end
    bit_stb = 1'b0;
    tick();
    if (unlock !== 1'b0 || o_dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL ok_close unlock=%b state=%0d exp 0/%0d", unlock, o_dbg_state, ST_IDLE);
    end
    checks++;
  endtask

  task automatic test_wrong_x3();
    for (int k = 1; k <= 3; k++) begin
      enter_code(4'b1111);
      tick();
      if (fail_pulse !== 1'b1 || fail_cnt !== 2'(k) || sr_clr !== 1'b1) begin
        failures++; $display("FAIL wrong%0d fail_pulse=%b fail_cnt=%0d sr_clr=%b exp 1/%0d/1", k, fail_pulse, fail_cnt, sr_clr, k);
      end
      checks++;
      if (k < 3) begin
        tick();
        if (fail_pulse !== 1'b0 || o_dbg_state !== ST_IDLE || alarm !== 1'b0) begin
          failures++; $display("FAIL wrong%0d_after pulse=%b state=%0d alarm=%b exp 0/%0d/0", k, fail_pulse, o_dbg_state, alarm, ST_IDLE);
        end
        checks++;
      end
    end
    if (alarm !== 1'b1) begin failures++; $display("FAIL lock1 alarm got=%b exp=1", alarm); end
    checks++;
    bit_stb = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      cancel = (i > 8);
      tick();
      if (alarm !== 1'b1 || entry_cnt !== 3'd0 || fail_pulse !== 1'b0) begin
        failures++; $display("FAIL lock%0d alarm=%b entry=%0d pulse=%b exp 1/0/0", i, alarm, entry_cnt, fail_pulse);
      end
      checks++;
    end
    bit_stb = 1'b0;
    cancel  = 1'b0;
    tick();
    if (alarm !== 1'b0 || fail_cnt !== 2'd0 || o_dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL lock_exit alarm=%b fail=%0d state=%0d exp 0/0/%0d", alarm, fail_cnt, o_dbg_state, ST_IDLE);
    end
    checks++;
  endtask

  task automatic test_fail_then_pass();
    enter_code(4'b0000);
    bit_stb = 1'b1;  // strobe during CHECK is dropped
    tick();
    bit_stb = 1'b0;
    if (fail_cnt !== 2'd1 || fail_pulse !== 1'b1 || entry_cnt !== 3'd0) begin
      failures++; $display("FAIL ftp_fail fail=%0d pulse=%b entry=%0d exp 1/1/0", fail_cnt, fail_pulse, entry_cnt);
    end
    checks++;
    enter_code(4'b1010);
    tick();
    if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
      failures++; $display("FAIL ftp_pass unlock=%b fail=%0d exp 1/0", unlock, fail_cnt);
    end
    checks++;
    close_door();
  endtask

  task automatic test_cancel();
    sr = 4'b0;
    strobe(1'b0);
    strobe(1'b1);
    if (entry_cnt !== 3'd2) begin failures++; $display("FAIL cancel_pre entry got=%0d exp=2", entry_cnt); end
    checks++;
    cancel  = 1'b1;
    bit_stb = 1'b1;
    tick();
    cancel  = 1'b0;
    bit_stb = 1'b0;
    if (entry_cnt !== 3'd0 || sr_clr !== 1'b1 || o_dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL cancel entry=%0d sr_clr=%b state=%0d exp 0/1/%0d", entry_cnt, sr_clr, o_dbg_state, ST_IDLE);
    end
    checks++;
    tick();
    if (sr_clr !== 1'b0) begin failures++; $display("FAIL cancel_clr_pulse sr_clr got=%b exp=0", sr_clr); end
    checks++;
    enter_code(4'b1010);
    tick();
    if (unlock !== 1'b1) begin failures++; $display("FAIL cancel_retry unlock got=%b exp=1", unlock); end
    checks++;
    close_door();
  endtask

  task automatic test_reset_mid();
    enter_code(4'b1010);
    tick();
    tick();
    tick();  // OPEN cycle 3
    RST = 1'b1;
    tick();
    RST = 1'b0;
    if ({unlock, alarm, fail_pulse, sr_clr} !== 4'b0000 || o_dbg_state !== ST_IDLE || entry_cnt !== 3'd0) begin
      failures++; $display("FAIL rst_open outs=%b state=%0d entry=%0d exp 0000/%0d/0", {unlock, alarm, fail_pulse, sr_clr}, o_dbg_state, entry_cnt, ST_IDLE);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      enter_code(4'b0001);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();  // LOCKOUT cycle 5
    if (alarm !== 1'b1) begin failures++; $display("FAIL rst_lock_pre alarm got=%b exp=1", alarm); end
    checks++;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    if ({unlock, alarm, fail_pulse, sr_clr} !== 4'b0000 || fail_cnt !== 2'd0 || o_dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL rst_lock outs=%b fail=%0d state=%0d exp 0000/0/%0d", {unlock, alarm, fail_pulse, sr_clr}, fail_cnt, o_dbg_state, ST_IDLE);
    end
    checks++;
  endtask

  task automatic test_pwchange();
    enter_code(4'b1010);
    tick();
    pw_set = 1'b1;
    tick();
    pw_set = 1'b0;
`ifdef DOORLOCK_PWCHANGE_EN
    if (unlock !== 1'b0 || sr_clr !== 1'b1 || o_dbg_state !== ST_NEWPW) begin
      failures++; $display("FAIL pw_enter unlock=%b sr_clr=%b state=%0d exp 0/1/%0d", unlock, sr_clr, o_dbg_state, ST_NEWPW);
    end
    checks++;
    enter_code(4'b0110);
    tick();
    if (o_dbg_state !== ST_IDLE || sr_clr !== 1'b1) begin
      failures++; $display("FAIL pw_store state=%0d sr_clr=%b exp %0d/1", o_dbg_state, sr_clr, ST_IDLE);
    end
    checks++;
    enter_code(4'b1010);
    tick();
    if (fail_pulse !== 1'b1 || unlock !== 1'b0) begin
      failures++; $display("FAIL pw_old pulse=%b unlock=%b exp 1/0", fail_pulse, unlock);
    end
    checks++;
    enter_code(4'b0110);
    tick();
    if (unlock !== 1'b1) begin failures++; $display("FAIL pw_new unlock got=%b exp=1", unlock); end
    checks++;
    close_door();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    enter_code(4'b1010);
    tick();
    if (unlock !== 1'b1) begin failures++; $display("FAIL pw_rst_default unlock got=%b exp=1", unlock); end
    checks++;
    close_door();
`else
    if (unlock !== 1'b1 || sr_clr !== 1'b0 || o_dbg_state !== ST_OPEN) begin
      failures++; $display("FAIL pw_ignored unlock=%b sr_clr=%b state=%0d exp 1/0/%0d", unlock, sr_clr, o_dbg_state, ST_OPEN);
    end
    checks++;
    close_door();
    enter_code(4'b0110);
    tick();
    if (fail_pulse !== 1'b1 || unlock !== 1'b0) begin
      failures++; $display("FAIL pw_new_rejected pulse=%b unlock=%b exp 1/0", fail_pulse, unlock);
    end
    checks++;
    enter_code(4'b1010);
    tick();
    if (unlock !== 1'b1) begin failures++; $display("FAIL pw_old_valid unlock got=%b exp=1", unlock); end
    checks++;
    close_door();
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    bit_stb  = 1'b0;
    cancel   = 1'b0;
    pw_set   = 1'b0;
    code_in  = 4'b0;
    sr       = 4'b0;
    test_reset();
    test_correct_code();
    test_wrong_x3();
    test_fail_then_pass();
    test_cancel();
    test_reset_mid();
    test_pwchange();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/doorlock_code_checker.md
Name: doorlock_code_checker

Overview:
- Consumer stage directly downstream of the 4-bit serial-in/parallel-out entry shift register.
- Counts entered bits. Once 4 bits are in, compares the parallel code against the stored password.
- Drives the door unlock, failed-attempt counting, alarm lockout, and a clear request back to the shift register.
- Sits between the keypad/bit-entry front end and the lock actuator/LED outputs.

Parameters:
- DEFAULT_CODE, 4'b1010, password loaded at reset.
- OPEN_CYCLES, 8, CLK cycles that unlock stays high after a match (must be ≥1).
- LOCK_CYCLES, 16, CLK cycles of alarm lockout (must be ≥1).
- MAX_FAIL, 3, consecutive mismatches that trigger lockout (must be ≥1).

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- bit_stb  in  1  one-cycle strobe: a bit is presented to the shift register (captured at this edge).
- code_in  in  4  {Q3,Q2,Q1,Q0} from the shift register; Q0 = first bit entered.
- cancel  in  1  abort current entry / close door early.
- pw_set  in  1  request password change (used only with the optional feature).
- unlock  out  1  door open.
- alarm  out  1  lockout active.
- fail_pulse  out  1  one-cycle pulse per mismatch.
- sr_clr  out  1  one-cycle pulse; OR'd into the shift register's RST.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures.
- entry_cnt  out  3  bits entered in the current attempt, 0..4.

Behaviour:
- One clock; reset is synchronous and active-high, ports named CLK and RST.
- Reset values: state=IDLE; unlock=0; alarm=0; fail_pulse=0; sr_clr=0; fail_cnt=0; entry_cnt=0; stored code=DEFAULT_CODE.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT, plus NEWPW with the optional feature.
- IDLE→ENTRY:
  - Transition on bit_stb.
  - entry_cnt increments on each bit_stb in IDLE/ENTRY.
  - The 4th strobe sets entry_cnt=4 and moves to CHECK.
- CHECK is exactly one cycle and samples code_in; the register has updated by then.
  - Match:
    - Next state OPEN; fail_cnt←0; unlock=1 from the next cycle.
    - Unlock holds for exactly OPEN_CYCLES cycles, then returns to IDLE.
  - Mismatch:
    - fail_pulse=1 for one cycle; fail_cnt increments.
    - If the new fail_cnt==MAX_FAIL: go to LOCKOUT.
    - Otherwise: go to IDLE.
  - Either outcome: sr_clr=1 in the cycle after CHECK; entry_cnt←0.
- OPEN:
  - bit_stb ignored.
  - cancel forces IDLE next cycle and drops unlock.
- LOCKOUT:
  - alarm=1 for exactly LOCK_CYCLES cycles.
  - bit_stb and cancel ignored.
  - On exit: fail_cnt←0, state IDLE.
- cancel in IDLE/ENTRY: entry_cnt←0; sr_clr pulses; state IDLE.
  - cancel and bit_stb in the same cycle: cancel wins; the strobe is not counted.
- bit_stb in CHECK is dropped and not counted.
- fail_cnt saturates at MAX_FAIL and never wraps.
- RST in any state, including mid-OPEN or mid-LOCKOUT, returns immediately to reset values next edge. The stored code also reverts to DEFAULT_CODE.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DOORLOCK_PWCHANGE_EN.
- With the macro defined:
  - pw_set while in OPEN: unlock drops, sr_clr pulses, state NEWPW.
  - NEWPW counts 4 bit_stb strobes, as in ENTRY. The next cycle stores code_in as the new password and returns to IDLE.
  - cancel in NEWPW returns to IDLE with the password unchanged.
- Without it: pw_set is ignored, NEWPW does not exist, and the password is constant DEFAULT_CODE.

Decomposition:
- Package doorlock_pkg holds:
  - state enum typedef;
  - CODE_W=4 and ENTRY_LEN=4 constants;
  - DEFAULT_CODE default value.
- One sub-module, doorlock_dwell_timer:
  - load/count-down timer with a done flag, width $clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1);
  - shared by OPEN and LOCKOUT.

Test Plan:
- Correct code: RST, then strobe bits 0,1,0,1 (code_in=4'b1010) → unlock=1 for exactly 8 cycles starting 2 cycles after the 4th strobe; fail_cnt=0; sr_clr pulses once.
- Wrong code ×3: enter 4'b1111 three times → fail_pulse thrice; fail_cnt goes 1, 2, then lockout. alarm=1 for exactly 16 cycles and strobes are ignored during it. fail_cnt=0 after.
- Fail then pass: one mismatch (fail_cnt=1), then the correct code → unlock and fail_cnt=0.
- Cancel: 2 strobes then cancel (with a simultaneous bit_stb) → entry_cnt=0, sr_clr pulse, IDLE. The next full correct entry unlocks.
- Reset mid-operation: RST asserted during OPEN cycle 3 and during LOCKOUT cycle 5 → all outputs at reset values after one edge.
- DOORLOCK_PWCHANGE_EN: unlock, pw_set, enter 4'b0110 → the old code 4'b1010 now fails and 4'b0110 unlocks. Without the macro, the same sequence leaves 4'b1010 valid.
